// File: rtl/muladd_if.sv
// Request/response bundle for the shift-add multiply-accumulate unit.
// The requester drives go/a/b/c; the unit returns ready/error/res.
interface muladd_if #(parameter int WIDTH = 16);
  logic             go;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             ready;
  logic             error;
  logic [WIDTH-1:0] res;

  modport master (output go, a, b, c, input  ready, error, res);
  modport slave  (input  go, a, b, c, output ready, error, res);
endinterface

// File: rtl/muladd.sv
// Sequential res = a*b + c, one multiplier bit per cycle, fixed WIDTH-cycle latency.
// error flags any result that does not fit in WIDTH bits; res keeps the wrapped low bits.
module muladd #(
  parameter int WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  muladd_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q,   acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q,   cnt_d;
  logic [WIDTH-1:0]   res_q,   res_d;
  logic               err_q,   err_d;
  logic               rdy_q,   rdy_d;
  logic [2*WIDTH-1:0] acc_sum;

  // Accumulator cannot overflow 2*WIDTH bits, so no carry-out is kept.
  assign acc_sum = mplier_q[0] ? acc_q + mcand_q : acc_q;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    err_d    = err_q;
    rdy_d    = rdy_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.go) begin
          mcand_d  = {{WIDTH{1'b0}}, bus.a};
          mplier_d = bus.b;
          acc_d    = {{WIDTH{1'b0}}, bus.c};
          cnt_d    = '0;
          rdy_d    = 1'b0;
          err_d    = 1'b0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          res_d   = acc_sum[WIDTH-1:0];
          err_d   = |acc_sum[2*WIDTH-1:WIDTH];
          rdy_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      err_q    <= err_d;
      rdy_q    <= rdy_d;
    end
  end

  assign bus.res   = res_q;
  assign bus.error = err_q;
  assign bus.ready = rdy_q;

endmodule

// File: tb/tb_muladd.sv
// Directed and randomized checks of muladd against a plain-arithmetic model of a*b+c.
module tb_muladd;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  muladd_if #(.WIDTH(W)) bus ();

  muladd #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request, scramble the inputs while busy, then check latency and result.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [W-1:0] tc,
                        input string tag);
    longint unsigned full;
    logic [W-1:0]    exp_res;
    logic            exp_err;
    int              n;
    full    = longint'(ta) * longint'(tb_) + longint'(tc);
    exp_res = full[W-1:0];
    exp_err = (full >= (64'd1 << W));
    bus.a = ta; bus.b = tb_; bus.c = tc; bus.go = 1'b1;
    cyc();
    bus.go = 1'b0;
    chk({tag, "_ready_low"}, {31'd0, bus.ready}, 32'd0);
    n = 0;
    while (!bus.ready && n < 40) begin
      bus.a = W'($urandom); bus.b = W'($urandom); bus.c = W'($urandom);
      cyc();
      n++;
    end
    chk({tag, "_latency"}, n, W);
    chk({tag, "_res"}, {16'd0, bus.res}, {16'd0, exp_res});
    chk({tag, "_err"}, {31'd0, bus.error}, {31'd0, exp_err});
    chk({tag, "_noX"}, {31'd0, $isunknown({bus.ready, bus.error, bus.res})}, 32'd0);
  endtask

  int n;

  initial begin
    bus.go = 1'b0; bus.a = '0; bus.b = '0; bus.c = '0;
    #12;
    chk("rst_ready", {31'd0, bus.ready}, 32'd0);
    chk("rst_error", {31'd0, bus.error}, 32'd0);
    chk("rst_res",   {16'd0, bus.res},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #4;

    run_op(16'd12, 16'd13, 16'd5, "basic");
    run_op(16'd0, 16'hFFFF, 16'd7, "zero_a");
    run_op(16'd0, 16'd0, 16'd0, "all_zero");
    run_op(16'd255, 16'd257, 16'd0, "fit_max");
    run_op(16'd256, 16'd256, 16'd0, "ovf_min");
    run_op(16'hFFFF, 16'hFFFF, 16'hFFFF, "ovf_max");

    for (int x = 0; x < 20; x++)
      for (int y = 1; y < 20; y++)
        run_op(W'(x / y), W'(y), W'(x % y), "roundtrip");

    for (int i = 0; i < 40; i++)
      run_op(W'($urandom_range(0, 400)), W'($urandom_range(0, 400)), W'($urandom), "rand_small");
    for (int i = 0; i < 20; i++)
      run_op(W'($urandom), W'($urandom), W'($urandom), "rand_full");

    // go mid-BUSY must be ignored
    bus.a = 16'd2; bus.b = 16'd2; bus.c = 16'd0; bus.go = 1'b1;
    cyc();
    bus.go = 1'b0;
    n = 0;
    repeat (4) begin cyc(); n++; end
    bus.a = 16'd3; bus.b = 16'd3; bus.c = 16'd0; bus.go = 1'b1;
    cyc(); n++;
    bus.go = 1'b0;
    while (!bus.ready && n < 40) begin cyc(); n++; end
    chk("busy_go_latency", n, W);
    chk("busy_go_res", {16'd0, bus.res}, 32'd4);

    // go held in DONE restarts with the operands then present
    bus.go = 1'b1;
    cyc();
    bus.go = 1'b0;
    chk("restart_ready_low", {31'd0, bus.ready}, 32'd0);
    n = 0;
    while (!bus.ready && n < 40) begin cyc(); n++; end
    chk("restart_latency", n, W);
    chk("restart_res", {16'd0, bus.res}, 32'd9);

    // asynchronous reset mid-operation
    bus.a = 16'd100; bus.b = 16'd100; bus.c = 16'd1; bus.go = 1'b1;
    cyc();
    bus.go = 1'b0;
    repeat (7) cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", {31'd0, bus.ready}, 32'd0);
    chk("arst_error", {31'd0, bus.error}, 32'd0);
    chk("arst_res",   {16'd0, bus.res},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (40) begin
      cyc();
      if (bus.ready !== 1'b0) n++;
    end
    chk("post_rst_idle", n, 0);

    run_op(16'd7, 16'd9, 16'd1, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muladd.md
# muladd

Sequential multiply-accumulate unit computing `res = a * b + c` over unsigned operands. It uses a shift-add datapath, one multiplier bit per cycle, behind the same `go`/`ready`/`error` handshake as `divmod`. It is the inverse of `divmod`: feeding it the quotient, divisor and remainder reconstructs the dividend. It sits beside `divmod` in the prime-generator datapath and serves as the in-system cross-check for division results.

## Interface
- `WIDTH`, default 16: operand and result width in bits.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset. Asserting low clears all state immediately; release is synchronous to `clk` in the system.
- `go`  in  1  start request, sampled on the rising edge.
- `a`  in  WIDTH  multiplicand, for example a quotient from `divmod`.
- `b`  in  WIDTH  multiplier, for example a divisor.
- `c`  in  WIDTH  addend, for example a remainder.
- `ready`  out  1  high when `res`/`error` hold a completed result.
- `error`  out  1  high when the full result does not fit in WIDTH bits.
- `res`  out  WIDTH  low WIDTH bits of `a*b+c`.

## Operation
- States: IDLE, BUSY, DONE. Reset puts the block in IDLE with `ready`=0, `error`=0 and `res`=0.
- IDLE or DONE, on a rising edge with `go`=1:
  - latch `a` into a 2*WIDTH multiplicand register (upper half zero);
  - latch `b` into the multiplier shift register;
  - load the 2*WIDTH accumulator with `c` (zero-extended);
  - clear the bit counter; clear `ready` and `error`; enter BUSY.
- BUSY, on each edge:
  - if the multiplier LSB is 1, add the multiplicand register to the accumulator;
  - shift the multiplicand left 1 and the multiplier right 1;
  - increment the counter.
- After the edge that processes bit WIDTH-1, enter DONE:
  - `res` = accumulator[WIDTH-1:0];
  - `error` = OR of accumulator[2*WIDTH-1:WIDTH];
  - `ready` = 1.
- The accumulator never overflows, since (2^W−1)^2 + (2^W−1) < 2^(2W). `error` therefore reports exactly the cases where the true result is ≥ 2^WIDTH.
- On error, `res` still carries the wrapped low bits (deterministic, never X).
- `go` during BUSY is ignored. The operation in flight is unaffected and no request is queued.
- In DONE, `res`/`error`/`ready` hold until the next accepted `go` or a reset.
- Input operands are only sampled on the accepting edge. Changes to `a`/`b`/`c` afterwards have no effect.
- The counter is ceil(log2(WIDTH))+1 bits wide and wraps never: the exit condition is count == WIDTH-1.

## Timing
- Latency is fixed at WIDTH cycles regardless of operand values, with no early exit.
  - Accepting edge E0; bits are processed on edges E1..EWIDTH.
  - `ready` rises after edge EWIDTH (16 cycles for WIDTH=16).
- `ready` falls after the accepting edge E0. It is low throughout BUSY.
- Back-to-back operation: `go` held high in DONE restarts on the next edge. Throughput is therefore one result per WIDTH+1 cycles.
- Reset low at any time, including mid-BUSY:
  - immediately forces IDLE with `ready`=0, `error`=0 and `res`=0;
  - the operation in flight is discarded;
  - no output may glitch to X.
- `go` sampled on the first edge after reset release is accepted normally.

## Test plan
- Basic: `a`=12, `b`=13, `c`=5, one-cycle `go` → `ready`=1 exactly 16 cycles after the accepting edge, `res`=161, `error`=0.
- Zero operands:
  - `a`=0, `b`=0xFFFF, `c`=7 → `res`=7, `error`=0;
  - `a`=0, `b`=0, `c`=0 → `res`=0, `error`=0.
- Overflow boundary:
  - `a`=255, `b`=257, `c`=0 → `res`=0xFFFF, `error`=0;
  - `a`=256, `b`=256, `c`=0 → `res`=0, `error`=1;
  - `a`=0xFFFF, `b`=0xFFFF, `c`=0xFFFF → `res`=0x0000, `error`=1.
- Round trip against `divmod`: for every `x` in 0..19 and `y` in 1..19, drive `a`=x/y, `b`=y, `c`=x%y → `res`=x, `error`=0, with no X on any output.
- Handshake:
  - pulse `go` with new operands (`a`=3, `b`=3, `c`=0) on cycle 5 of BUSY for `a`=2, `b`=2, `c`=0 → result is `res`=4, and `ready` stays low until cycle 16;
  - then hold `go` high in DONE → a new operation starts, `ready` drops for 16 cycles, then `res`=9.
- Reset mid-operation: start `a`=100, `b`=100, `c`=1, drive `rst` low at cycle 8 → `ready`, `error` and `res` are 0 immediately, without waiting for a clock edge. After release with no `go`, `ready` stays 0 indefinitely.
